// File: rtl/ca_row_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ca_row_ctrl_pkg
//   Shared defaults and FSM state encoding for the CA row sequencer.
//   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ca_row_ctrl_pkg;

  // Default geometry: 2560 pixels per row at 16 bits per word.
  localparam int CA_WORDS = 160;
  localparam int CA_AW    = 8;
  localparam int CA_DW    = 16;

  // Row-fill sequencer states.
  typedef enum logic [1:0] {
    CA_IDLE  = 2'd0,
    CA_START = 2'd1,
    CA_FILL  = 2'd2,
    CA_READY = 2'd3
  } ca_state_e;

  // Beat counter must reach WORDS itself without wrapping.
  function automatic int ca_cnt_width(input int words);
    return $clog2(words + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ca_wr_arb.sv
// ---------------------------------------------------------------------------
// ca_wr_arb
//   Two-way fixed-priority write mux for the line-buffer write port.
//   Generator beats win; the host is granted in any cycle without a beat.
//   All mem_* outputs are registered (one cycle after acceptance/grant).
//   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ca_wr_arb #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          gen_vld_i,
  input  logic [AW:0]   gen_addr_i,
  input  logic [DW-1:0] gen_data_i,
  input  logic          dbg_req_i,
  input  logic [AW:0]   dbg_addr_i,
  input  logic [DW-1:0] dbg_data_i,
  output logic          dbg_gnt_o,
  output logic          mem_we_o,
  output logic [AW:0]   mem_waddr_o,
  output logic [DW-1:0] mem_wdata_o
);

  logic          we_q,    we_d;
  logic [AW:0]   waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          gnt;

  // Host grant is combinational; held low while reset is asserted.
  assign gnt = dbg_req_i & ~gen_vld_i & rst_n;

  // Select the winning requester; hold address/data when nobody writes.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (gen_vld_i) begin
      we_d    = 1'b1;
      waddr_d = gen_addr_i;
      wdata_d = gen_data_i;
    end else if (gnt) begin
      we_d    = 1'b1;
      waddr_d = dbg_addr_i;
      wdata_d = dbg_data_i;
    end
  end

  // Register the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign dbg_gnt_o   = gnt;
  assign mem_we_o    = we_q;
  assign mem_waddr_o = waddr_q;
  assign mem_wdata_o = wdata_q;

endmodule

`default_nettype wire

// File: rtl/ca_row_ctrl.sv
// ---------------------------------------------------------------------------
// ca_row_ctrl
//   Sequences the CA row generator into a ping-pong line buffer. The
//   generator fills the back bank (~front_bank) while scan-out reads the
//   front bank; banks swap on line_sync only once the back bank is full.
//   A late line_sync re-displays the front bank and sets sticky overrun.
//   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ca_row_ctrl
  import ca_row_ctrl_pkg::*;
#(
  parameter int WORDS = CA_WORDS,
  parameter int AW    = CA_AW,
  parameter int DW    = CA_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          line_sync,
  output logic          gen_start,
  input  logic          gen_write,
  input  logic [AW-1:0] gen_waddr,
  input  logic [DW-1:0] gen_wdata,
  input  logic          dbg_req,
  input  logic          dbg_bank,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_data,
  output logic          dbg_gnt,
  output logic          mem_we,
  output logic [AW:0]   mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          front_bank,
  output logic          overrun,
  input  logic          overrun_clr
);

  localparam int            CW        = ca_cnt_width(WORDS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(WORDS - 1);
  localparam logic [AW:0]   WORDS_LIM = (AW+1)'(WORDS);

  ca_state_e     state_q,   state_d;
  logic          front_q,   front_d;
  logic [CW-1:0] count_q,   count_d;
  logic          overrun_q, overrun_d;
  logic          beat_acc;
  logic          ovr_set;

  // A beat only counts in FILL and only for an in-range word address.
  assign beat_acc = (state_q == CA_FILL) && gen_write && ({1'b0, gen_waddr} < WORDS_LIM);

  // Next-state, bank swap, beat counting and overrun detection.
  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    count_d   = count_q;
    gen_start = 1'b0;
    ovr_set   = 1'b0;
    case (state_q)
      CA_IDLE: begin
        if (enable) state_d = CA_START;
      end
      CA_START: begin
        gen_start = 1'b1;
        count_d   = '0;
        state_d   = CA_FILL;
      end
      CA_FILL: begin
        if (beat_acc) begin
          count_d = count_q + 1'b1;
          if (count_q == LAST_BEAT) state_d = CA_READY;
        end
      end
      CA_READY: begin
        if (line_sync) begin
          front_d = ~front_q;
          state_d = enable ? CA_START : CA_IDLE;
        end
      end
      default: state_d = CA_IDLE;
    endcase
    // A line_sync before READY is a missed swap, unless we are idle and
    // disabled. A final beat coinciding with line_sync is still late.
    if (line_sync && (state_q != CA_READY) &&
        (enable || (state_q == CA_START) || (state_q == CA_FILL)))
      ovr_set = 1'b1;
    // Set has priority over clear.
    overrun_d = ovr_set | (overrun_q & ~overrun_clr);
  end

  // State, bank select, counter and sticky overrun registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CA_IDLE;
      front_q   <= 1'b0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      front_q   <= front_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  ca_wr_arb #(
    .AW (AW),
    .DW (DW)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .gen_vld_i   (beat_acc),
    .gen_addr_i  ({~front_q, gen_waddr}),
    .gen_data_i  (gen_wdata),
    .dbg_req_i   (dbg_req),
    .dbg_addr_i  ({dbg_bank, dbg_addr}),
    .dbg_data_i  (dbg_data),
    .dbg_gnt_o   (dbg_gnt),
    .mem_we_o    (mem_we),
    .mem_waddr_o (mem_waddr),
    .mem_wdata_o (mem_wdata)
  );

  assign front_bank = front_q;
  assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_ca_row_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ca_row_ctrl
//   Self-checking bench for ca_row_ctrl: expected line-buffer writes are
//   queued as stimulus is driven and compared as mem_we appears.
//   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ca_row_ctrl;

  localparam int WORDS = 160;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        line_sync;
  logic        gen_start;
  logic        gen_write;
  logic [7:0]  gen_waddr;
  logic [15:0] gen_wdata;
  logic        dbg_req;
  logic        dbg_bank;
  logic [7:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic        dbg_gnt;
  logic        mem_we;
  logic [8:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic        front_bank;
  logic        overrun;
  logic        overrun_clr;

  int n_vec = 0;
  int n_bad = 0;
  int gnt_seen;
  logic [24:0] sb[$];

  ca_row_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .line_sync   (line_sync),
    .gen_start   (gen_start),
    .gen_write   (gen_write),
    .gen_waddr   (gen_waddr),
    .gen_wdata   (gen_wdata),
    .dbg_req     (dbg_req),
    .dbg_bank    (dbg_bank),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .dbg_gnt     (dbg_gnt),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .front_bank  (front_bank),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_sync();
    line_sync = 1'b1;
    tick();
    line_sync = 1'b0;
  endtask

  task automatic wait_start(input string tag, output int n);
    n = 0;
    while (!gen_start && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(gen_start), 32'd1);
  endtask

  // Drives a full row of in-range beats into the given back bank.
  task automatic do_fill(input logic bank, input int ls_beat);
    for (int i = 0; i < WORDS; i++) begin
      gen_write = 1'b1;
      gen_waddr = 8'(i);
      gen_wdata = 16'($urandom);
      line_sync = (i == ls_beat);
      sb.push_back({bank, gen_waddr, gen_wdata});
      #1;
      if (dbg_gnt) gnt_seen++;
      tick();
    end
    gen_write = 1'b0;
    line_sync = 1'b0;
  endtask

  // Scoreboard: every registered write must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (mem_we) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", {23'd0, mem_waddr}, 32'h1ff);
      end else begin
        logic [24:0] e;
        e = sb.pop_front();
        chk("sb_waddr", 32'(mem_waddr), 32'(e[24:16]));
        chk("sb_wdata", 32'(mem_wdata), 32'(e[15:0]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int starts;
    rst_n = 1'b0; enable = 1'b0; line_sync = 1'b0; gen_write = 1'b0;
    gen_waddr = '0; gen_wdata = '0; dbg_req = 1'b0; dbg_bank = 1'b0;
    dbg_addr = '0; dbg_data = '0; overrun_clr = 1'b0; gnt_seen = 0;
    repeat (3) tick();
    chk("rst_front",     32'(front_bank), 32'd0);
    chk("rst_mem_we",    32'(mem_we),     32'd0);
    chk("rst_mem_waddr", 32'(mem_waddr),  32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata),  32'd0);
    chk("rst_gen_start", 32'(gen_start),  32'd0);
    chk("rst_dbg_gnt",   32'(dbg_gnt),    32'd0);
    chk("rst_overrun",   32'(overrun),    32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_disabled", 32'(gen_start), 32'd0);

    // 1: first row into bank 1, then swap
    enable = 1'b1;
    wait_start("t1_start", n);
    chk("t1_latency", 32'(n), 32'd1);
    tick();
    chk("t1_pulse_width", 32'(gen_start), 32'd0);
    do_fill(1'b1, -1);
    chk("t1_no_overrun", 32'(overrun), 32'd0);
    pulse_sync();
    chk("t1_front", 32'(front_bank), 32'd1);
    chk("t1_restart", 32'(gen_start), 32'd1);

    // 2: line_sync mid-fill, then clear behaviour
    tick();
    do_fill(1'b0, 80);
    chk("t2_overrun", 32'(overrun), 32'd1);
    chk("t2_front_held", 32'(front_bank), 32'd1);
    pulse_sync();
    chk("t2_swap", 32'(front_bank), 32'd0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("t2_clear", 32'(overrun), 32'd0);
    line_sync = 1'b1; overrun_clr = 1'b1;
    tick();
    line_sync = 1'b0; overrun_clr = 1'b0;
    chk("t2_set_beats_clear", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("t2_clear2", 32'(overrun), 32'd0);

    // 3: host request held across a full burst
    dbg_req = 1'b1; dbg_bank = 1'b0; dbg_addr = 8'd5; dbg_data = 16'hA5A5;
    gnt_seen = 0;
    do_fill(1'b1, -1);
    chk("t3_no_gnt_in_burst", 32'(gnt_seen), 32'd0);
    #1;
    chk("t3_gnt_first_idle", 32'(dbg_gnt), 32'd1);
    sb.push_back({1'b0, 8'd5, 16'hA5A5});
    tick();
    dbg_req = 1'b0;

    // 4: stray beats while READY are dropped, FSM stays READY
    gen_write = 1'b1; gen_waddr = 8'd200; gen_wdata = 16'h1234;
    tick();
    gen_waddr = 8'd3;
    tick();
    gen_write = 1'b0;
    pulse_sync();
    chk("t4_swap", 32'(front_bank), 32'd1);
    chk("t4_restart", 32'(gen_start), 32'd1);

    // 5: enable dropped during FILL; out-of-range beat not counted
    tick();
    enable = 1'b0;
    gen_write = 1'b1; gen_waddr = 8'd160; gen_wdata = 16'hBEEF;
    tick();
    gen_write = 1'b0;
    do_fill(1'b0, -1);
    pulse_sync();
    chk("t5_front", 32'(front_bank), 32'd0);
    chk("t5_no_start", 32'(gen_start), 32'd0);
    pulse_sync();
    chk("t5_idle_no_overrun", 32'(overrun), 32'd0);
    starts = 0;
    repeat (6) begin
      tick();
      if (gen_start) starts++;
    end
    chk("t5_idle_hold", 32'(starts), 32'd0);
    enable = 1'b1;
    wait_start("t5_restart", n);
    tick();
    do_fill(1'b1, -1);
    pulse_sync();
    chk("t5_front2", 32'(front_bank), 32'd1);

    // 6: async reset mid-fill
    tick();
    for (int i = 0; i < 50; i++) begin
      gen_write = 1'b1;
      gen_waddr = 8'(i);
      gen_wdata = 16'($urandom);
      line_sync = (i == 20);
      sb.push_back({1'b0, gen_waddr, gen_wdata});
      tick();
    end
    line_sync = 1'b0;
    chk("t6_overrun_pre", 32'(overrun), 32'd1);
    gen_waddr = 8'd50; dbg_req = 1'b1; dbg_bank = 1'b1; dbg_addr = 8'd9;
    rst_n = 1'b0;
    #1;
    chk("t6_front",     32'(front_bank), 32'd0);
    chk("t6_mem_we",    32'(mem_we),     32'd0);
    chk("t6_mem_waddr", 32'(mem_waddr),  32'd0);
    chk("t6_mem_wdata", 32'(mem_wdata),  32'd0);
    chk("t6_gen_start", 32'(gen_start),  32'd0);
    chk("t6_dbg_gnt",   32'(dbg_gnt),    32'd0);
    chk("t6_overrun",   32'(overrun),    32'd0);
    dbg_req = 1'b0;
    repeat (3) begin
      gen_waddr = gen_waddr + 8'd1;
      tick();
    end
    rst_n = 1'b1;
    n = 0;
    while (!gen_start && n < 20) begin
      gen_waddr = gen_waddr + 8'd1;
      tick();
      n++;
    end
    chk("t6_restart", 32'(gen_start), 32'd1);
    tick();
    do_fill(1'b1, 159);
    chk("t6_final_beat_overrun", 32'(overrun), 32'd1);
    chk("t6_front_held", 32'(front_bank), 32'd0);
    pulse_sync();
    chk("t6_swap", 32'(front_bank), 32'd1);

    enable = 1'b0;
    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
